decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 64: register data width.
REQ-002 SHALL have parameter NUM_FWD, default 3, legal range 1..8: number of forwarding channels; channel 0 is youngest and has highest priority.
REQ-003 SHALL have ports clk, input, 1: clock; all state updates on rising edge.
REQ-004 SHALL have ports reset, input, 1: synchronous active-high reset.
REQ-005 SHALL have ports in_valid in 1, in_ready out 1, in_inst in 32, in_pc in XLEN: upstream (fetch) handshake and payload.
REQ-006 SHALL have ports rs1_addr out 5, rs2_addr out 5: combinational register-file read addresses, equal to in_inst[19:15] and in_inst[24:20].
REQ-007 SHALL have ports rs1_rdata in XLEN, rs2_rdata in XLEN: same-cycle register-file read data.
REQ-008 SHALL have ports fwd_valid in NUM_FWD, fwd_addr in NUM_FWD*5, fwd_data in NUM_FWD*XLEN, fwd_data_ok in NUM_FWD: per-channel pending write; data_ok=0 means the result does not exist yet (load in flight).
REQ-009 SHALL have port flush, input, 1: squash the decode stage.
REQ-010 SHALL have ports out_valid out 1, out_ready in 1: downstream (execute) handshake.
REQ-011 SHALL have ports out_inst out 32, out_pc out XLEN, out_rs1_addr out 5, out_rs2_addr out 5, out_rs1_val out XLEN, out_rs2_val out XLEN, out_rd_addr out 5, out_rd_we out 1: registered decode payload.
REQ-012 SHALL have port stall_count, output, 32: saturating count of hazard-stall cycles.

Function
REQ-013 SHALL resolve each source operand: if the address is 0, value 0; else the lowest-index channel with fwd_valid=1 and matching fwd_addr supplies fwd_data; else rs*_rdata.
REQ-014 SHALL ignore any channel whose fwd_addr is 0.
REQ-015 SHALL assert hazard when in_valid=1 and the winning channel for either non-zero source has fwd_data_ok=0; a lower-priority channel with data_ok=1 SHALL NOT override this.
REQ-016 SHALL drive in_ready = (!out_valid || out_ready) && !hazard && !flush.
REQ-017 SHALL capture the payload into the output registers on a rising edge where in_valid && in_ready, and set out_valid=1 with a latency of exactly one cycle.
REQ-018 SHALL clear out_valid when out_ready=1 and there is no new capture; payload registers SHALL then hold their last values.
REQ-019 SHALL hold all outputs stable while out_valid=1 and out_ready=0.
REQ-020 SHALL set out_rd_addr = in_inst[11:7], and set out_rd_we=0 when opcode in_inst[6:0] is 0100011 (store) or 1100011 (branch), or when rd=0; otherwise out_rd_we=1.
REQ-021 SHALL clear out_valid on the next edge after flush=1, regardless of in_valid and out_ready; flush takes priority over capture and hazard.
REQ-022 SHALL increment stall_count on every edge where hazard=1 and flush=0, and saturate at 0xFFFF_FFFF.
REQ-023 SHALL produce no combinational path from out_ready to any out_* payload signal.

Reset
REQ-024 SHALL, on an edge with reset=1, set out_valid=0, all out_* payload registers to 0, and stall_count=0; reset overrides flush and capture.
REQ-025 SHALL keep in_ready combinational during reset; a beat accepted in a reset cycle SHALL be discarded.

Configuration
REQ-026 SHALL compile forwarding in when the macro DECODE_FWD_EN is defined: REQ-013 to REQ-015 apply.
REQ-027 SHALL, when DECODE_FWD_EN is undefined, never forward; hazard SHALL assert whenever any channel with fwd_valid=1 and non-zero fwd_addr matches a non-zero source, regardless of fwd_data_ok, and the operand SHALL come from rs*_rdata.

Verification
REQ-028 SHALL cover basic forwarding: inst add x3,x1,x2; fwd0={valid,addr 1,data 0x11,ok 1}; fwd2={valid,addr 1,data 0x22,ok 1}; rs1_rdata=0x99 -> next cycle out_rs1_val=0x11, out_valid=1.
REQ-029 SHALL cover load-use stall: fwd0={addr 2,ok 0} for 3 cycles, then ok=1 with data 0x5 -> in_ready=0 for 3 cycles, stall_count=3, then out_rs2_val=0x5.
REQ-030 SHALL cover backpressure: out_ready=0 for 4 cycles with out_valid=1 -> outputs unchanged, in_ready=0; out_ready=1 -> next beat captured the following edge.
REQ-031 SHALL cover x0 and store rules: sw x0,0(x5) with fwd0={addr 0,data 0xFF} -> out_rs2_val=0, out_rd_we=0.
REQ-032 SHALL cover flush mid-stall: a hazard is active, flush=1 for 1 cycle -> out_valid=0 the next cycle, stall_count not incremented in the flush cycle.
REQ-033 SHALL cover the non-forwarding build: with DECODE_FWD_EN undefined, the REQ-028 stimulus -> in_ready=0 until fwd_valid deasserts, then out_rs1_val=0x99.

Source files
------------

// File: rtl/decode_stage.sv
// Decode stage: operand resolution with optional forwarding, hazard stall, registered payload.
// Forwarding is compiled in only when DECODE_FWD_EN is defined.
module decode_stage #(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned NUM_FWD = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [31:0]             in_inst,
   input  logic [XLEN-1:0]         in_pc,
   output logic [4:0]              rs1_addr,
   output logic [4:0]              rs2_addr,
   input  logic [XLEN-1:0]         rs1_rdata,
   input  logic [XLEN-1:0]         rs2_rdata,
   input  logic [NUM_FWD-1:0]      fwd_valid,
   input  logic [NUM_FWD*5-1:0]    fwd_addr,
   input  logic [NUM_FWD*XLEN-1:0] fwd_data,
   input  logic [NUM_FWD-1:0]      fwd_data_ok,
   input  logic                    flush,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_inst,
   output logic [XLEN-1:0]         out_pc,
   output logic [4:0]              out_rs1_addr,
   output logic [4:0]              out_rs2_addr,
   output logic [XLEN-1:0]         out_rs1_val,
   output logic [XLEN-1:0]         out_rs2_val,
   output logic [4:0]              out_rd_addr,
   output logic                    out_rd_we,
   output logic [31:0]             stall_count
);

   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic            rs1_hz;
   logic            rs2_hz;
   logic            hazard;
   logic            capture;
   logic            rd_we;
   logic [4:0]      rd_addr;
   logic [6:0]      opcode;

   assign rs1_addr = in_inst[19:15];
   assign rs2_addr = in_inst[24:20];
   assign rd_addr  = in_inst[11:7];
   assign opcode   = in_inst[6:0];

`ifdef DECODE_FWD_EN
   // Returns {hazard, value}; the first matching channel wins even if its data is not ready.
   function automatic logic [XLEN:0] resolve(
      input logic [4:0]              src,
      input logic [XLEN-1:0]         rdata,
      input logic [NUM_FWD-1:0]      v,
      input logic [NUM_FWD*5-1:0]    a,
      input logic [NUM_FWD*XLEN-1:0] d,
      input logic [NUM_FWD-1:0]      ok
   );
      logic            found;
      logic            hz;
      logic [XLEN-1:0] val;
      found = 1'b0;
      hz    = 1'b0;
      val   = rdata;
      if (src == '0) begin
         val = '0;
      end else begin
         for (int unsigned i = 0; i < NUM_FWD; i++) begin
            if (!found && v[i] && (a[i*5 +: 5] != '0) && (a[i*5 +: 5] == src)) begin
               found = 1'b1;
               val   = d[i*XLEN +: XLEN];
               hz    = !ok[i];
            end
         end
      end
      return {hz, val};
   endfunction

   always_comb begin
      {rs1_hz, rs1_val} = resolve(rs1_addr, rs1_rdata, fwd_valid, fwd_addr, fwd_data, fwd_data_ok);
      {rs2_hz, rs2_val} = resolve(rs2_addr, rs2_rdata, fwd_valid, fwd_addr, fwd_data, fwd_data_ok);
   end
`else
   // Without forwarding any pending writer to a live source blocks issue.
   function automatic logic [XLEN:0] resolve(
      input logic [4:0]           src,
      input logic [XLEN-1:0]      rdata,
      input logic [NUM_FWD-1:0]   v,
      input logic [NUM_FWD*5-1:0] a
   );
      logic            hz;
      logic [XLEN-1:0] val;
      hz  = 1'b0;
      val = rdata;
      if (src == '0) begin
         val = '0;
      end else begin
         for (int unsigned i = 0; i < NUM_FWD; i++) begin
            if (v[i] && (a[i*5 +: 5] != '0) && (a[i*5 +: 5] == src)) begin
               hz = 1'b1;
            end
         end
      end
      return {hz, val};
   endfunction

   logic unused_fwd;
   assign unused_fwd = ^{fwd_data, fwd_data_ok};

   always_comb begin
      {rs1_hz, rs1_val} = resolve(rs1_addr, rs1_rdata, fwd_valid, fwd_addr);
      {rs2_hz, rs2_val} = resolve(rs2_addr, rs2_rdata, fwd_valid, fwd_addr);
   end
`endif

   assign hazard   = in_valid && (rs1_hz || rs2_hz);
   assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
   assign capture  = in_valid && in_ready;
   assign rd_we    = !((opcode == OP_STORE) || (opcode == OP_BRANCH) || (rd_addr == '0));

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid    <= 1'b0;
         out_inst     <= '0;
         out_pc       <= '0;
         out_rs1_addr <= '0;
         out_rs2_addr <= '0;
         out_rs1_val  <= '0;
         out_rs2_val  <= '0;
         out_rd_addr  <= '0;
         out_rd_we    <= 1'b0;
         stall_count  <= '0;
      end else begin
         if (flush) begin
            out_valid <= 1'b0;
         end else if (capture) begin
            out_valid    <= 1'b1;
            out_inst     <= in_inst;
            out_pc       <= in_pc;
            out_rs1_addr <= rs1_addr;
            out_rs2_addr <= rs2_addr;
            out_rs1_val  <= rs1_val;
            out_rs2_val  <= rs2_val;
            out_rd_addr  <= rd_addr;
            out_rd_we    <= rd_we;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (hazard && !flush && (stall_count != '1)) begin
            stall_count <= stall_count + 32'd1;
         end
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage; expectations follow the DECODE_FWD_EN build setting.
module tb_decode_stage;
   localparam int XLEN = 64;
   localparam int NF   = 3;

   logic              clk = 1'b0;
   logic              reset;
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_inst;
   logic [XLEN-1:0]   in_pc;
   logic [4:0]        rs1_addr;
   logic [4:0]        rs2_addr;
   logic [XLEN-1:0]   rs1_rdata;
   logic [XLEN-1:0]   rs2_rdata;
   logic [NF-1:0]     fwd_valid;
   logic [NF*5-1:0]   fwd_addr;
   logic [NF*XLEN-1:0] fwd_data;
   logic [NF-1:0]     fwd_data_ok;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_inst;
   logic [XLEN-1:0]   out_pc;
   logic [4:0]        out_rs1_addr;
   logic [4:0]        out_rs2_addr;
   logic [XLEN-1:0]   out_rs1_val;
   logic [XLEN-1:0]   out_rs2_val;
   logic [4:0]        out_rd_addr;
   logic              out_rd_we;
   logic [31:0]       stall_count;

   decode_stage #(.XLEN(XLEN), .NUM_FWD(NF)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_rdata(rs1_rdata), .rs2_rdata(rs2_rdata),
      .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data), .fwd_data_ok(fwd_data_ok),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .out_inst(out_inst), .out_pc(out_pc), .out_rs1_addr(out_rs1_addr), .out_rs2_addr(out_rs2_addr),
      .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val), .out_rd_addr(out_rd_addr),
      .out_rd_we(out_rd_we), .stall_count(stall_count)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] ADD_X3 = 32'h002081B3;  // add x3,x1,x2
   localparam logic [31:0] ADD_X4 = 32'h00208233;  // add x4,x1,x2
   localparam logic [31:0] SW_X0  = 32'h0002A023;  // sw x0,0(x5)
   localparam logic [31:0] BEQ_8  = 32'h00208463;  // beq x1,x2,8

   int          compared   = 0;
   int          mismatched = 0;
   logic [31:0] exp_stall;
   logic [63:0] held_rs2;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_fwd(input int ch, input logic v, input logic [4:0] a,
                          input logic [63:0] d, input logic ok);
      fwd_valid[ch]          = v;
      fwd_addr[ch*5 +: 5]    = a;
      fwd_data[ch*64 +: 64]  = d;
      fwd_data_ok[ch]        = ok;
   endtask

   task automatic clr_fwd;
      fwd_valid   = '0;
      fwd_addr    = '0;
      fwd_data    = '0;
      fwd_data_ok = '0;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b1; in_inst = ADD_X3; in_pc = 64'h1000;
      rs1_rdata = 64'h99; rs2_rdata = 64'h77; flush = 1'b0; out_ready = 1'b1;
      clr_fwd();
      exp_stall = 32'd0;

      // Reset: in_ready stays combinational, accepted beat is dropped.
      tick();
      chk("ready_in_reset", 64'(in_ready), 64'd1);
      tick();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_inst", 64'(out_inst), 64'd0);
      chk("rst_out_pc", out_pc, 64'd0);
      chk("rst_rs1_val", out_rs1_val, 64'd0);
      chk("rst_rd_we", 64'(out_rd_we), 64'd0);
      chk("rst_stall", 64'(stall_count), 64'd0);
      reset = 1'b0; in_valid = 1'b0;
      tick();

      // Basic forwarding: channel 0 beats channel 2.
      set_fwd(0, 1'b1, 5'd1, 64'h11, 1'b1);
      set_fwd(2, 1'b1, 5'd1, 64'h22, 1'b1);
      in_valid = 1'b1;
      #1;
      chk("rs1_addr_comb", 64'(rs1_addr), 64'd1);
      chk("rs2_addr_comb", 64'(rs2_addr), 64'd2);
`ifdef DECODE_FWD_EN
      chk("fwd_ready", 64'(in_ready), 64'd1);
      tick();
      chk("fwd_rs1_val", out_rs1_val, 64'h11);
`else
      chk("nofwd_ready0", 64'(in_ready), 64'd0);
      tick(); exp_stall++;
      chk("nofwd_ready1", 64'(in_ready), 64'd0);
      tick(); exp_stall++;
      chk("nofwd_stall", 64'(stall_count), 64'(exp_stall));
      chk("nofwd_no_cap", 64'(out_valid), 64'd0);
      clr_fwd();
      #1;
      chk("nofwd_ready_rel", 64'(in_ready), 64'd1);
      tick();
      chk("nofwd_rs1_val", out_rs1_val, 64'h99);
`endif
      chk("a_out_valid", 64'(out_valid), 64'd1);
      chk("a_rs2_val", out_rs2_val, 64'h77);
      chk("a_out_pc", out_pc, 64'h1000);
      chk("a_out_inst", 64'(out_inst), 64'(ADD_X3));
      chk("a_rd_addr", 64'(out_rd_addr), 64'd3);
      chk("a_rd_we", 64'(out_rd_we), 64'd1);
      chk("a_rs1_addr", 64'(out_rs1_addr), 64'd1);
      chk("a_rs2_addr", 64'(out_rs2_addr), 64'd2);
      in_valid = 1'b0; clr_fwd();
      tick();
      chk("drain_valid", 64'(out_valid), 64'd0);
      chk("drain_hold_pc", out_pc, 64'h1000);

      // Load-use: youngest writer not ready; older ready writer must not win.
      in_inst = ADD_X4; in_pc = 64'h1004; rs1_rdata = 64'h10; rs2_rdata = 64'h20;
      set_fwd(0, 1'b1, 5'd2, 64'hAA, 1'b0);
      set_fwd(1, 1'b1, 5'd2, 64'h33, 1'b1);
      in_valid = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("lu_ready", 64'(in_ready), 64'd0);
         tick(); exp_stall++;
      end
      chk("lu_stall", 64'(stall_count), 64'(exp_stall));
      chk("lu_no_cap", 64'(out_valid), 64'd0);
      set_fwd(0, 1'b1, 5'd2, 64'h5, 1'b1);
      #1;
`ifdef DECODE_FWD_EN
      chk("lu_ready_ok", 64'(in_ready), 64'd1);
      tick();
      held_rs2 = 64'h5;
`else
      chk("lu_ready_ok", 64'(in_ready), 64'd0);
      tick(); exp_stall++;
      clr_fwd();
      #1;
      chk("lu_ready_rel", 64'(in_ready), 64'd1);
      tick();
      held_rs2 = 64'h20;
`endif
      chk("lu_rs2_val", out_rs2_val, held_rs2);
      chk("lu_rs1_val", out_rs1_val, 64'h10);
      chk("lu_valid", 64'(out_valid), 64'd1);
      chk("lu_rd_addr", 64'(out_rd_addr), 64'd4);
      chk("lu_stall_hold", 64'(stall_count), 64'(exp_stall));

      // Backpressure: outputs frozen while out_ready=0.
      clr_fwd();
      out_ready = 1'b0; in_inst = ADD_X3; in_pc = 64'h2000; rs1_rdata = 64'h55; rs2_rdata = 64'h66;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("bp_ready", 64'(in_ready), 64'd0);
         tick();
         chk("bp_valid", 64'(out_valid), 64'd1);
         chk("bp_pc", out_pc, 64'h1004);
         chk("bp_rs2", out_rs2_val, held_rs2);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_ready_rel", 64'(in_ready), 64'd1);
      tick();
      chk("bp_new_pc", out_pc, 64'h2000);
      chk("bp_new_rs1", out_rs1_val, 64'h55);
      chk("bp_new_rs2", out_rs2_val, 64'h66);
      chk("bp_new_valid", 64'(out_valid), 64'd1);

      // x0 source and store: channel with address 0 is ignored.
      in_inst = SW_X0; in_pc = 64'h3000; rs1_rdata = 64'h123; rs2_rdata = 64'hDEAD;
      set_fwd(0, 1'b1, 5'd0, 64'hFF, 1'b0);
      #1;
      chk("sw_ready", 64'(in_ready), 64'd1);
      chk("sw_rs1_addr_comb", 64'(rs1_addr), 64'd5);
      tick();
      chk("sw_rs2_val", out_rs2_val, 64'd0);
      chk("sw_rs1_val", out_rs1_val, 64'h123);
      chk("sw_rd_we", 64'(out_rd_we), 64'd0);
      chk("sw_rd_addr", 64'(out_rd_addr), 64'd0);
      chk("sw_rs1_addr", 64'(out_rs1_addr), 64'd5);
      clr_fwd();
      in_inst = BEQ_8; in_pc = 64'h3004;
      tick();
      chk("beq_rd_addr", 64'(out_rd_addr), 64'd8);
      chk("beq_rd_we", 64'(out_rd_we), 64'd0);
      chk("beq_pc", out_pc, 64'h3004);

      // Flush mid-stall with a valid output held.
      out_ready = 1'b0; in_inst = ADD_X4; in_pc = 64'h4000;
      set_fwd(0, 1'b1, 5'd2, 64'h0, 1'b0);
      flush = 1'b1;
      #1;
      chk("fl_ready", 64'(in_ready), 64'd0);
      tick();
      chk("fl_valid", 64'(out_valid), 64'd0);
      chk("fl_stall", 64'(stall_count), 64'(exp_stall));
      flush = 1'b0; out_ready = 1'b1;
      #1;
      chk("fl_hz_ready", 64'(in_ready), 64'd0);
      tick(); exp_stall++;
      chk("fl_stall_resume", 64'(stall_count), 64'(exp_stall));

      // Flush beats an otherwise acceptable capture.
      clr_fwd();
      flush = 1'b1;
      #1;
      chk("fc_ready", 64'(in_ready), 64'd0);
      tick();
      chk("fc_valid", 64'(out_valid), 64'd0);
      chk("fc_pc_hold", out_pc, 64'h3004);
      flush = 1'b0;
      tick();
      chk("fc_cap_valid", 64'(out_valid), 64'd1);
      chk("fc_cap_pc", out_pc, 64'h4000);

      // Reset overrides capture and clears the counter.
      reset = 1'b1;
      tick();
      chk("r2_valid", 64'(out_valid), 64'd0);
      chk("r2_stall", 64'(stall_count), 64'd0);
      chk("r2_pc", out_pc, 64'd0);
      chk("r2_rs1", out_rs1_val, 64'd0);
      reset = 1'b0; in_valid = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
